// File: rtl/stream_buf_loader.sv
// stream_buf_loader: takes one load command at a time (target buffer, base, length), consumes a
// valid/ready stream of DDR words and emits registered write strobe/address/data for fm/wt/bias.
//
// Ports:
//   clk, rst                          clock and synchronous active-high reset
//   cmd_valid/cmd_ready               command handshake
//   cmd_sel, cmd_base, cmd_len        0=fm 1=wt 2=bias 3=reserved; first address; word count
//   s_valid/s_ready/s_data            stream word handshake and payload
//   buf_addr_o, buf_data_o            shared write address/data (hold between writes)
//   fm_wr_en_o/wt_wr_en_o/bias_wr_en_o per-buffer write strobes
//   busy, load_done, load_err         in-progress flag; completion / rejection pulses
module stream_buf_loader #(
    parameter  int DATA_W     = 32,
    parameter  int FM_DEPTH   = 1024,
    parameter  int WT_DEPTH   = 1024,
    parameter  int BIAS_DEPTH = 256,
    localparam int MAX_D01    = (FM_DEPTH > WT_DEPTH) ? FM_DEPTH : WT_DEPTH,
    localparam int MAX_DEPTH  = (MAX_D01 > BIAS_DEPTH) ? MAX_D01 : BIAS_DEPTH,
    localparam int ADDR_W     = $clog2(MAX_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_sel,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic [ADDR_W-1:0] buf_addr_o,
    output logic [DATA_W-1:0] buf_data_o,
    output logic              fm_wr_en_o,
    output logic              wt_wr_en_o,
    output logic              bias_wr_en_o,
    output logic              busy,
    output logic              load_done,
    output logic              load_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    // Depths carry one extra bit so a depth equal to 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] FM_D   = (ADDR_W+1)'(FM_DEPTH);
    localparam logic [ADDR_W:0] WT_D   = (ADDR_W+1)'(WT_DEPTH);
    localparam logic [ADDR_W:0] BIAS_D = (ADDR_W+1)'(BIAS_DEPTH);

    function automatic logic [ADDR_W:0] depth_of(input logic [1:0] sel);
        logic [ADDR_W:0] d;
        d = '0;
        case (sel)
            2'd0:    d = FM_D;
            2'd1:    d = WT_D;
            2'd2:    d = BIAS_D;
            default: d = '0;
        endcase
        return d;
    endfunction

    state_t            state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] baddr_d;
    logic [DATA_W-1:0] bdata_d;
    logic              fm_d, wt_d, bias_d, done_d, err_d;
    logic [ADDR_W:0]   cmd_depth, cur_depth;

    assign cmd_ready = (state_q == IDLE);
    assign s_ready   = (state_q == LOAD);
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        baddr_d   = buf_addr_o;
        bdata_d   = buf_data_o;
        fm_d      = 1'b0;
        wt_d      = 1'b0;
        bias_d    = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        cmd_depth = depth_of(cmd_sel);
        cur_depth = depth_of(sel_q);
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_sel == 2'd3 || {1'b0, cmd_base} >= cmd_depth) begin
                        err_d = 1'b1;
                    end else if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = LOAD;
                        sel_d   = cmd_sel;
                        addr_d  = cmd_base;
                        cnt_d   = cmd_len;
                    end
                end
            end
            LOAD: begin
                if (s_valid) begin
                    baddr_d = addr_q;
                    bdata_d = s_data;
                    fm_d    = (sel_q == 2'd0);
                    wt_d    = (sel_q == 2'd1);
                    bias_d  = (sel_q == 2'd2);
                    // Wrap at the selected buffer's depth, not at 2**ADDR_W.
                    if ({1'b0, addr_q} == cur_depth - 1'b1) begin
                        addr_d = '0;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == ADDR_W'(1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            addr_q       <= '0;
            cnt_q        <= '0;
            buf_addr_o   <= '0;
            buf_data_o   <= '0;
            fm_wr_en_o   <= 1'b0;
            wt_wr_en_o   <= 1'b0;
            bias_wr_en_o <= 1'b0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            buf_addr_o   <= baddr_d;
            buf_data_o   <= bdata_d;
            fm_wr_en_o   <= fm_d;
            wt_wr_en_o   <= wt_d;
            bias_wr_en_o <= bias_d;
            load_done    <= done_d;
            load_err     <= err_d;
        end
    end

endmodule

// File: tb/tb_stream_buf_loader.sv
// tb_stream_buf_loader: directed stimulus against a beat-index model of the loader,
// checked every cycle, plus literal expectations on the captured write log.
module tb_stream_buf_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_sel = '0;
    logic [9:0]  cmd_base = '0;
    logic [9:0]  cmd_len = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic [9:0]  buf_addr_o;
    logic [31:0] buf_data_o;
    logic        fm_wr_en_o, wt_wr_en_o, bias_wr_en_o;
    logic        busy, load_done, load_err;

    stream_buf_loader dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_sel(cmd_sel), .cmd_base(cmd_base), .cmd_len(cmd_len),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .buf_addr_o(buf_addr_o), .buf_data_o(buf_data_o),
        .fm_wr_en_o(fm_wr_en_o), .wt_wr_en_o(wt_wr_en_o),
        .bias_wr_en_o(bias_wr_en_o),
        .busy(busy), .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int done_cyc = 0;
    int n_done = 0;
    int n_err = 0;
    int n_sready = 0;
    logic [44:0] wlog[$];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic int depth(input logic [1:0] s);
        case (s)
            2'd0:    return 1024;
            2'd1:    return 1024;
            2'd2:    return 256;
            default: return 0;
        endcase
    endfunction

    // Model: phase 0 idle, 1 loading, 2 completion cycle. Address of beat k is
    // (base + k) mod depth, computed directly from the beat index.
    int          phase = 0;
    int          m_base, m_len, m_k;
    logic [1:0]  m_sel;
    logic        e_fm, e_wt, e_bias, e_done, e_err;
    logic [9:0]  e_addr;
    logic [31:0] e_data;
    bit          chk_en = 0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            phase = 0;
            {e_fm, e_wt, e_bias, e_done, e_err} = '0;
            e_addr = '0;
            e_data = '0;
        end else begin
            {e_fm, e_wt, e_bias, e_done, e_err} = '0;
            if (phase == 0) begin
                if (cmd_valid) begin
                    if (cmd_sel == 2'd3 || int'(cmd_base) >= depth(cmd_sel)) begin
                        e_err = 1'b1;
                    end else if (cmd_len == 10'd0) begin
                        e_done = 1'b1;
                    end else begin
                        m_sel  = cmd_sel;
                        m_base = int'(cmd_base);
                        m_len  = int'(cmd_len);
                        m_k    = 0;
                        phase  = 1;
                    end
                end
            end else if (phase == 1) begin
                if (s_valid) begin
                    e_addr = 10'((m_base + m_k) % depth(m_sel));
                    e_data = s_data;
                    e_fm   = (m_sel == 2'd0);
                    e_wt   = (m_sel == 2'd1);
                    e_bias = (m_sel == 2'd2);
                    m_k++;
                    if (m_k == m_len) begin
                        e_done = 1'b1;
                        phase  = 2;
                    end
                end
            end else begin
                phase = 0;
            end
        end
        chk_en = 1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cycle",
                  {fm_wr_en_o, wt_wr_en_o, bias_wr_en_o, load_done, load_err,
                   cmd_ready, s_ready, busy, buf_addr_o, buf_data_o},
                  {e_fm, e_wt, e_bias, e_done, e_err,
                   phase == 0, phase == 1, phase != 0, e_addr, e_data});
            check("excl",
                  {62'd0, load_done & load_err,
                   (int'(fm_wr_en_o) + int'(wt_wr_en_o) + int'(bias_wr_en_o)) > 1},
                  64'd0);
            if (fm_wr_en_o | wt_wr_en_o | bias_wr_en_o)
                wlog.push_back({fm_wr_en_o, wt_wr_en_o, bias_wr_en_o,
                                buf_addr_o, buf_data_o});
            if (load_done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (load_err) n_err++;
            if (s_ready) n_sready++;
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_cmd(input logic [1:0] s, input int b, input int l);
        cmd_valid = 1'b1;
        cmd_sel   = s;
        cmd_base  = 10'(b);
        cmd_len   = 10'(l);
        for (int i = 0; i < 200 && !cmd_ready; i++) tick(1);
        if (!cmd_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL cmd_timeout: got cmd_ready=0 want 1");
        end else begin
            acc_cyc = cyc;
            tick(1);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d);
        s_valid = 1'b1;
        s_data  = d;
        for (int i = 0; i < 200 && !s_ready; i++) tick(1);
        if (!s_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL beat_timeout: got s_ready=0 want 1");
        end else begin
            tick(1);
        end
        s_valid = 1'b0;
    endtask

    task automatic clr();
        wlog.delete();
        n_done   = 0;
        n_err    = 0;
        n_sready = 0;
    endtask

    task automatic chk_w(input int i, input logic [2:0] st, input int a,
                         input logic [31:0] d);
        logic [44:0] got;
        got = (i < wlog.size()) ? wlog[i] : 45'h0;
        check($sformatf("wr%0d", i), {19'd0, got}, {19'd0, st, 10'(a), d});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        tick(3);
        rst = 1'b0;
        check("rst_state",
              {fm_wr_en_o, wt_wr_en_o, bias_wr_en_o, load_done, load_err,
               cmd_ready, s_ready, busy, buf_addr_o, buf_data_o},
              {8'b0000_0100, 42'd0});

        // Basic fm load
        clr();
        send_cmd(2'd0, 10, 4);
        beat(32'hA000_000A);
        beat(32'hB000_000B);
        beat(32'hC000_000C);
        beat(32'hD000_000D);
        tick(3);
        check("basic_n", wlog.size(), 4);
        chk_w(0, 3'b100, 10, 32'hA000_000A);
        chk_w(1, 3'b100, 11, 32'hB000_000B);
        chk_w(2, 3'b100, 12, 32'hC000_000C);
        chk_w(3, 3'b100, 13, 32'hD000_000D);
        check("basic_done", n_done, 1);

        // Bias wrap
        clr();
        send_cmd(2'd2, 254, 4);
        for (int i = 0; i < 4; i++) beat(32'h100 + 32'(i));
        tick(3);
        check("wrap_n", wlog.size(), 4);
        chk_w(0, 3'b001, 254, 32'h100);
        chk_w(1, 3'b001, 255, 32'h101);
        chk_w(2, 3'b001, 0, 32'h102);
        chk_w(3, 3'b001, 1, 32'h103);

        // Backpressure: valid 1,0,0,1,0,1
        clr();
        send_cmd(2'd1, 500, 3);
        beat(32'h11);
        tick(2);
        beat(32'h22);
        tick(1);
        beat(32'h33);
        tick(3);
        check("bp_n", wlog.size(), 3);
        chk_w(0, 3'b010, 500, 32'h11);
        chk_w(1, 3'b010, 501, 32'h22);
        chk_w(2, 3'b010, 502, 32'h33);

        // Rejects and zero length
        clr();
        send_cmd(2'd3, 0, 5);
        tick(3);
        check("rej3_err", n_err, 1);
        send_cmd(2'd2, 256, 5);
        tick(3);
        check("rejbase_err", n_err, 2);
        send_cmd(2'd0, 7, 0);
        s_valid = 1'b1;
        tick(3);
        s_valid = 1'b0;
        check("len0_done", n_done, 1);
        check("len0_sready", n_sready, 0);
        check("rej_writes", wlog.size(), 0);

        // Reset mid-load
        clr();
        send_cmd(2'd0, 0, 8);
        beat(32'h1);
        beat(32'h2);
        beat(32'h3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rst_ready_busy", {cmd_ready, busy}, 2'b10);
        s_valid = 1'b1;
        tick(1);
        s_valid = 1'b0;
        tick(2);
        check("rst_n", wlog.size(), 3);
        chk_w(2, 3'b100, 2, 32'h3);

        // Command held during a load
        clr();
        send_cmd(2'd1, 0, 2);
        fork
            send_cmd(2'd0, 5, 1);
            begin
                beat(32'hE1);
                beat(32'hE2);
            end
        join
        check("hold_acc", acc_cyc, done_cyc + 1);
        beat(32'hF1);
        tick(3);
        check("hold_n", wlog.size(), 3);
        chk_w(2, 3'b100, 5, 32'hF1);
        check("hold_done", n_done, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
